// File: rtl/switch_out_port.sv
// -----------------------------------------------------------------------------
// switch_out_port
//
// Store-and-forward output port. Bytes arrive from the switching fabric and are
// written into a circular buffer. A packet becomes visible to the reader only
// when its last byte has been written (commit). Committed packets are then
// presented one byte at a time on port_out using a ready/read handshake. If a
// packet does not fit, all of its bytes are discarded, so a partial packet
// never reaches the port.
//
// Optional feature macro: SWITCH_OUT_DROP_CNT_EN adds the drop_cnt output, a
// saturating 16-bit count of discarded packets.
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst_n       asynchronous active-low reset
//   in_data     byte from fabric
//   in_valid    in_data valid this cycle
//   in_last     qualifies in_valid: final byte of the packet
//   in_full     registered: occupancy >= DEPTH-1 (advisory to fabric)
//   port_out    current byte, valid while port_ready = 1 (registered)
//   port_ready  a byte of a committed packet is presented (registered)
//   port_read   consumer takes port_out at this edge
//   pkt_count   committed packets not yet fully read
//   drop_cnt    dropped-packet counter (SWITCH_OUT_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module switch_out_port #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_full,
  output logic [7:0]                 port_out,
  output logic                       port_ready,
  input  logic                       port_read,
  output logic [$clog2(DEPTH):0]     pkt_count
`ifdef SWITCH_OUT_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Buffer entry: {last flag, byte}. No reset on the array so it maps to RAM.
  logic [8:0]    mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic          drop_q, drop_d;
  logic          in_full_q;
  state_t        state_q, state_d;
  logic [7:0]    port_out_q;
  logic          port_last_q;
  logic          port_ready_q;

  logic [PW-1:0] occ;
  logic [PW-1:0] occ_next;
  logic          buf_full;
  logic          wr_en;
  logic          overflow;
  logic          pkt_push;
  logic          pkt_pop;
  logic          load;
  logic [AW-1:0] rd_addr;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign buf_full = (occ == PW'(DEPTH));
  assign wr_en    = in_valid && !drop_q && !buf_full;
  assign overflow = in_valid && !drop_q && buf_full;
  assign pkt_push = wr_en && in_last;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = drop_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (in_last) begin
        commit_ptr_d = wr_ptr_q + 1'b1;
      end
    end else if (overflow) begin
      // Throw away the uncommitted part of the packet. If this byte already
      // ends the packet there is nothing left to skip, so drop mode is not
      // entered.
      wr_ptr_d = commit_ptr_q;
      drop_d   = !in_last;
    end else if (in_valid && drop_q && in_last) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    pkt_pop  = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_count_q != '0) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (port_read) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (port_last_q) begin
            pkt_pop = 1'b1;
            state_d = GAP;
          end else begin
            // Next byte of the same packet is already committed in the buffer.
            load = 1'b1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The output register is loaded from the address the read pointer will hold
  // after this edge, so the presented byte always tracks rd_ptr.
  assign rd_addr     = rd_ptr_d[AW-1:0];
  assign pkt_count_d = pkt_count_q + PW'(pkt_push) - PW'(pkt_pop);
  assign occ_next    = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      pkt_count_q  <= '0;
      drop_q       <= 1'b0;
      in_full_q    <= 1'b0;
      state_q      <= IDLE;
      port_out_q   <= 8'h00;
      port_last_q  <= 1'b0;
      port_ready_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_q       <= drop_d;
      in_full_q    <= (occ_next >= PW'(DEPTH - 1));
      state_q      <= state_d;
      port_ready_q <= (state_d == SEND);
      if (load) begin
        {port_last_q, port_out_q} <= mem_q[rd_addr];
      end
    end
  end

  assign in_full    = in_full_q;
  assign port_out   = port_out_q;
  assign port_ready = port_ready_q;
  assign pkt_count  = pkt_count_q;

  // ---------------------------------------------------------------------------
  // Optional drop counter: one count per discarded packet, saturating.
  // ---------------------------------------------------------------------------
`ifdef SWITCH_OUT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'h0000;
    end else if (overflow && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'h0001;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Counter absent; drop behaviour above is unchanged.
`endif

endmodule

// File: tb/tb_switch_out_port.sv
module tb_switch_out_port;

  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_full;
  logic [7:0]    port_out;
  logic          port_ready;
  logic          port_read;
  logic [PW-1:0] pkt_count;
`ifdef SWITCH_OUT_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  switch_out_port #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_full    (in_full),
    .port_out   (port_out),
    .port_ready (port_ready),
    .port_read  (port_read),
    .pkt_count  (pkt_count)
`ifdef SWITCH_OUT_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write one packet of n bytes: byte i = base + i*step, last flag on the final byte.
  task automatic send_pkt(input logic [7:0] base, input int n, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + i * step);
      in_last  = (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("write pkt base=%02h len=%0d pkt_count=%0d in_full=%0b", base, n, pkt_count, in_full);
  endtask

  // Read one packet back-to-back and check every byte.
  task automatic read_pkt(input logic [7:0] base, input int n, input logic [7:0] step);
    port_read = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("rd_ready", port_ready, 1);
      chk("rd_byte", port_out, 8'(base + i * step));
      tick();
    end
    port_read = 1'b0;
    chk("rd_ready_fall", port_ready, 0);
    $display("read pkt base=%02h len=%0d pkt_count=%0d", base, n, pkt_count);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!port_ready && n < 8) begin
      tick();
      n++;
    end
    chk("wait_ready", port_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    port_read = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_ready", port_ready, 0);
    chk("rst_out", port_out, 8'h00);
    chk("rst_full", in_full, 0);
    chk("rst_pkt", pkt_count, 0);
`ifdef SWITCH_OUT_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: AA,BB,CC; ready two edges after CC, read every cycle
    send_pkt(8'hAA, 3, 8'h11);
    chk("t1_pkt_commit", pkt_count, 1);
    chk("t1_ready_lat0", port_ready, 0);
    tick();
    read_pkt(8'hAA, 3, 8'h11);
    chk("t1_pkt_done", pkt_count, 0);
    tick();
    chk("t1_gap", port_ready, 0);
    tick();
    chk("t1_idle", port_ready, 0);

    // 2: stall 10 cycles, then a toggled read pattern
    send_pkt(8'h11, 3, 8'h11);
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("t2_hold_out", port_out, 8'h11);
    chk("t2_hold_ready", port_ready, 1);
    port_read = 1'b1; tick();
    chk("t2_b1", port_out, 8'h22);
    port_read = 1'b0; tick();
    chk("t2_b1_hold", port_out, 8'h22);
    port_read = 1'b1; tick();
    chk("t2_b2", port_out, 8'h33);
    port_read = 1'b0; tick();
    chk("t2_b2_hold", port_out, 8'h33);
    chk("t2_b2_ready", port_ready, 1);
    port_read = 1'b1; tick();
    port_read = 1'b0;
    chk("t2_done_ready", port_ready, 0);
    chk("t2_done_pkt", pkt_count, 0);
    $display("toggled read of pkt base=11 done");

    // 3: P1 (6B) unread, P2 (5B) overflows and is dropped, P3 (2B) fits
    send_pkt(8'h10, 6, 8'h01);
    chk("t3_p1_full", in_full, 0);
    send_pkt(8'h20, 5, 8'h01);
    chk("t3_p2_pkt", pkt_count, 1);
    chk("t3_p2_full", in_full, 0);
`ifdef SWITCH_OUT_DROP_CNT_EN
    chk("t3_drop_cnt", drop_cnt, 1);
`endif
    send_pkt(8'h30, 2, 8'h01);
    chk("t3_p3_pkt", pkt_count, 2);
    chk("t3_p3_full", in_full, 1);
    read_pkt(8'h10, 6, 8'h01);
    tick();
    chk("t3_gap", port_ready, 0);
    wait_ready();
    read_pkt(8'h30, 2, 8'h01);
    chk("t3_pkt_done", pkt_count, 0);

    // 4: 9-byte packet into an empty 8-deep buffer is dropped
    tick();
    tick();
    send_pkt(8'h40, 9, 8'h01);
    chk("t4_pkt", pkt_count, 0);
    chk("t4_full", in_full, 0);
    tick(); tick(); tick();
    chk("t4_ready", port_ready, 0);

    // 5: commit of B on the same edge as the last pop of A
    port_read = 1'b1;
    in_valid = 1'b1; in_last = 1'b0; in_data = 8'hA0; tick();
    in_last = 1'b1; in_data = 8'hA1; tick();
    chk("t5_a_commit", pkt_count, 1);
    in_last = 1'b0; in_data = 8'hB0; tick();
    chk("t5_a0", port_out, 8'hA0);
    chk("t5_a0_ready", port_ready, 1);
    in_data = 8'hB1; tick();
    chk("t5_a1", port_out, 8'hA1);
    in_last = 1'b1; in_data = 8'hB2; tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t5_pkt_same", pkt_count, 1);
    chk("t5_fall", port_ready, 0);
    tick();
    chk("t5_gap", port_ready, 0);
    tick();
    chk("t5_b0", port_out, 8'hB0);
    chk("t5_b0_ready", port_ready, 1);
    tick();
    chk("t5_b1", port_out, 8'hB1);
    tick();
    chk("t5_b2", port_out, 8'hB2);
    tick();
    chk("t5_done", pkt_count, 0);
    $display("commit-and-pop pkts A,B done");

    // 6: continuous 4-byte packets while reading, pointers wrap several times
    begin
      int idx = 0;
      fork
        begin
          for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < 4; b++) begin
              in_valid = 1'b1;
              in_data  = 8'((p * 4 + b) * 3 + 7);
              in_last  = (b == 3);
              tick();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            tick(); tick(); tick();
          end
        end
        begin
          for (int c = 0; c < 60; c++) begin
            if (port_ready) begin
              chk("t6_byte", port_out, 8'(idx * 3 + 7));
              idx++;
            end
            tick();
          end
        end
      join
      chk("t6_count", idx, 24);
      chk("t6_pkt", pkt_count, 0);
      $display("stream of 6 pkts read bytes=%0d", idx);
    end

    // 7: reset during SEND with a partial packet in flight
    port_read = 1'b0;
    tick();
    send_pkt(8'h61, 3, 8'h01);
    tick();
    port_read = 1'b1; tick();
    port_read = 1'b0;
    chk("t7_pre_out", port_out, 8'h62);
    in_valid = 1'b1; in_data = 8'h81; tick();
    in_data = 8'h82; tick();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t7_rst_ready", port_ready, 0);
    chk("t7_rst_out", port_out, 8'h00);
    chk("t7_rst_pkt", pkt_count, 0);
    chk("t7_rst_full", in_full, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(8'h71, 2, 8'h01);
    chk("t7_new_pkt", pkt_count, 1);
    tick();
    read_pkt(8'h71, 2, 8'h01);
    chk("t7_done", pkt_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
